// File: rtl/array_13_ctrl.sv
// Request-side controller for the 32x2 single-port masked array macro.
// Arbitrates write/read requests onto RW0, zero-fills after reset.
module array_13_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 2,
  parameter int RESP_DEPTH  = 2,
  parameter bit INIT_ENABLE = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  init_done,
  output logic                  mem_en,
  output logic                  mem_wmode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW =
    (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 2);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_P =
    PW'(RESP_DEPTH - 1);

  // BOOT holds the reset-time outputs for one cycle
  typedef enum logic [1:0] {
    BOOT,
    INIT,
    RUN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_done_q;
  logic                  rd_first_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;

  logic          run;
  logic          push;
  logic          pop;
  logic [CW-1:0] credit;
  logic          rd_elig;
  logic          rd_want;
  logic          wr_fire;
  logic          rd_fire;
  logic          conflict;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign run        = state_q == RUN;
  assign push       = inflight_q;
  assign resp_valid = count_q != '0;
  assign resp_data  = fifo_q[head_q];
  assign pop        = resp_valid & resp_ready;
  assign init_done  = init_done_q;

  assign credit  = count_q + CW'(inflight_q);
  assign rd_elig = run & ((credit < DEPTH_C) |
                   ((credit == DEPTH_C) & pop));
  assign rd_want = rd_valid & rd_elig;

  // rd_first_q=1: read wins the next conflict
  assign rd_ready = rd_elig &
                    (~wr_valid | rd_first_q);
  assign wr_ready = run &
                    ~(rd_want & rd_first_q);

  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;
  assign conflict = wr_valid & rd_want;

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    unique case (state_q)
      BOOT: begin
        state_d = INIT_ENABLE ? INIT : RUN;
      end
      INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = init_addr_q;
        mem_wmask = '1;
        if (&init_addr_q) state_d = RUN;
      end
      RUN: begin
        unique case (1'b1)
          wr_fire: begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = wr_addr;
            mem_wmask = wr_mask;
            mem_wdata = wr_data;
          end
          rd_fire: begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
          end
          default: ;
        endcase
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BOOT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      rd_first_q  <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_q |
                     (state_d == RUN);
      if (state_q == INIT)
        init_addr_q <= init_addr_q + 1'b1;
      if (conflict)
        rd_first_q <= ~rd_first_q;
      inflight_q <= rd_fire;
    end
  end

  // macro read data lands one edge after issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RESP_DEPTH; i++)
        fifo_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_q[tail_q] <= mem_rdata;
        tail_q         <= nxt(tail_q);
      end
      if (pop)
        head_q <= nxt(head_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && count_q == DEPTH_C)
  );

  a_one_grant: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(wr_fire && rd_fire)
  );

endmodule

// File: doc/array_13_ctrl.md
Name: array_13_ctrl

Overview:
Request-side controller placed directly upstream of the 32x2 single-port masked array macro. It accepts independent write and read requests over valid/ready channels and arbitrates them onto the macro's single RW port. It captures read data into a small response FIFO and zero-initialises the whole array after reset. Upstream logic never drives the macro directly.

Parameters:
ADDR_WIDTH, 5, macro address width (depth = 2^ADDR_WIDTH = 32)
DATA_WIDTH, 2, word width; mask granularity is 1 bit, so mask width = DATA_WIDTH
RESP_DEPTH, 2, response FIFO entries; also the outstanding-read credit limit
INIT_ENABLE, 1, 1 = zero-fill the array after reset; 0 = skip the fill (init_done rises the first cycle after reset release)

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
wr_valid / wr_ready  in / out  1 / 1  write request handshake
wr_addr / wr_mask / wr_data  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH  write address, per-bit mask, write data
rd_valid / rd_ready  in / out  1 / 1  read request handshake
rd_addr  in  ADDR_WIDTH  read address
resp_valid / resp_ready  out / in  1 / 1  read response handshake
resp_data  out  DATA_WIDTH  read response data, in request order
init_done  out  1  high once the fill completes; stays high until reset
mem_en / mem_wmode  out  1 / 1  to macro RW0_en / RW0_wmode
mem_addr / mem_wmask / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH  to macro RW0_addr / RW0_wmask / RW0_wdata
mem_rdata  in  DATA_WIDTH  from macro RW0_rdata; valid the cycle after a read is issued

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values: mem_en=0, mem_wmode=0, mem_addr/wmask/wdata=0, wr_ready=0, rd_ready=0, resp_valid=0, resp_data=0, init_done=0.
- Reset asserted mid-operation: FIFO and in-flight read are discarded, credits cleared, fill restarts from address 0.
- States: INIT and RUN.
  - INIT: entered after reset release when INIT_ENABLE=1. Per cycle: mem_en=1, mem_wmode=1, mem_wmask=all ones, mem_wdata=0, address 0..31 in order. After 32 cycles go to RUN; init_done rises the cycle after address 31 is issued. wr_ready=rd_ready=0 throughout INIT.
  - INIT_ENABLE=0: go straight to RUN.
- Macro drive (RUN): mem_* is combinational from the granted request; one macro access per cycle at most. mem_en=0 when there is no grant.
- Ready rules: a ready may depend on the other channel's valid, never on its own valid.
- Write grant:
  - wr_ready=1 in RUN unless a read is also requested and wins arbitration.
  - An accepted write drives mem_en=1, mem_wmode=1, addr/mask/data straight through.
  - wr_mask=00 is still accepted and issued; the array is unchanged.
- Read eligibility: credit = in-flight reads (0 or 1) + FIFO occupancy. A read may issue when credit < RESP_DEPTH, or when credit == RESP_DEPTH and a response pops this cycle.
- Read grant: rd_ready=1 when the read is eligible and wins (or has no) arbitration. An accepted read drives mem_en=1, mem_wmode=0, mem_addr=rd_addr.
- Arbitration: when wr_valid and an eligible rd_valid coincide, a last-winner bit selects the channel that lost the previous conflict. The bit flips only on conflict cycles. It resets to favour write.
- Read latency: read issued at edge N; mem_rdata is sampled into the FIFO at edge N+1; resp_valid is high from cycle N+2 (earliest). No bypass path.
- FIFO: in-order, RESP_DEPTH entries. Push and pop in the same cycle are both legal. resp_data comes from the registered head. resp_data is held stable while resp_valid=1 and resp_ready=0.
- Write to A accepted at cycle N, then read of A at N+1: the read returns the new data.
- Read of A at N, then write to A at N+1: the read returns the old data, because capture happens on the same edge as the write.
- Credit never exceeds RESP_DEPTH. FIFO overflow is impossible by construction. Assertion: a push into a full FIFO is an error.

Test Plan:
- Reset, INIT_ENABLE=1 -> 32 consecutive write cycles, addr 0..31, mask 11, data 00; init_done=1 on cycle 33; then reading every address returns 00.
- Write addr 5 data 10 mask 11, then read addr 5 next cycle -> resp_data=10 with resp_valid two cycles after the read handshake.
- Write addr 7 data 11 mask 11, then data 00 mask 10 -> read addr 7 returns 01.
- Hold resp_ready=0 and issue 3 reads -> only 2 accepted, rd_ready=0 on the third. Set resp_ready=1 -> responses come out in order and the third read is accepted in the same cycle as the first pop.
- wr_valid and rd_valid high together for 4 cycles (credits available) -> grants alternate W,R,W,R; never two macro accesses in one cycle.
- Assert reset_n low for 1 cycle with 2 responses buffered and 1 read in flight -> resp_valid=0 immediately, INIT restarts at addr 0, no stale response appears afterwards.
